// File: rtl/iob_rom_arb.sv
// Round-robin arbiter that shares one synchronous-read ROM port between NUM_REQ
// requester lanes. At most one read is in flight. A response can be accepted and a
// new read issued in the same cycle, so the arbiter sustains one read per cycle.
module iob_rom_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 11,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic                      rom_r_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_r_data,
  output logic                      busy
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One spare bit so last_q + offset can exceed NUM_REQ-1 before the modulo fold.
  localparam logic [ID_W:0] NumReqW = (ID_W + 1)'(NUM_REQ);

  logic            rsp_pend_q, rsp_pend_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [ID_W-1:0] last_q, last_d;

  logic            rsp_fire;
  logic            can_issue;
  logic            issue;
  logic            found;
  logic [ID_W-1:0] pick;

  assign rsp_fire  = rsp_pend_q & rsp_ready[rsp_id_q];
  assign can_issue = ~rsp_pend_q | rsp_fire;
  // Gating with arst_n keeps every output low while reset is asserted.
  assign issue     = arst_n & can_issue & found;

  // Round-robin pick: search upward from last_q+1, wrapping at NUM_REQ.
  always_comb begin
    logic [ID_W:0] sum;
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      sum = {1'b0, last_q} + (ID_W + 1)'(off);
      if (sum >= NumReqW) begin
        sum = sum - NumReqW;
      end
      if (!found && req_valid[sum[ID_W-1:0]]) begin
        found = 1'b1;
        pick  = sum[ID_W-1:0];
      end
    end
  end

  // Request-side outputs: grant and ROM access only in an issue cycle.
  always_comb begin
    req_ready = '0;
    rom_r_en  = 1'b0;
    rom_addr  = '0;
    if (issue) begin
      req_ready[pick] = 1'b1;
      rom_r_en        = 1'b1;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (ID_W'(i) == pick) begin
          rom_addr = req_addr[i*ADDR_W +: ADDR_W];
        end
      end
    end
  end

  // Response-side outputs: ROM data passes straight through, held by the ROM while idle.
  always_comb begin
    rsp_valid           = '0;
    rsp_valid[rsp_id_q] = rsp_pend_q;
    rsp_data            = rom_r_data;
    busy                = rsp_pend_q;
  end

  // Next-state: issue takes priority over a plain response accept.
  always_comb begin
    rsp_pend_d = rsp_pend_q;
    rsp_id_d   = rsp_id_q;
    last_d     = last_q;
    if (issue) begin
      rsp_pend_d = 1'b1;
      rsp_id_d   = pick;
      last_d     = pick;
    end else if (rsp_fire) begin
      rsp_pend_d = 1'b0;
    end
  end

  // State registers; last_q resets to the top lane so lane 0 wins first.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rsp_pend_q <= 1'b0;
      rsp_id_q   <= '0;
      last_q     <= ID_W'(NUM_REQ - 1);
    end else begin
      rsp_pend_q <= rsp_pend_d;
      rsp_id_q   <= rsp_id_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: tb/tb_iob_rom_arb.sv
// Bench for iob_rom_arb: a 4-lane instance and a 3-lane instance, each behind a
// behavioural ROM with rom[k] = k * 0x01010101. Expected responses are queued when a
// grant is checked and popped when the response is checked.
module tb_iob_rom_arb;

  typedef struct {
    int          lane;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        arst_n;

  logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [43:0] req_addr;
  logic [31:0] rsp_data, rom_r_data;
  logic        rom_r_en, busy;
  logic [10:0] rom_addr;

  logic [2:0]  req_valid3, req_ready3, rsp_valid3, rsp_ready3;
  logic [32:0] req_addr3;
  logic [31:0] rsp_data3, rom_r_data3;
  logic        rom_r_en3, busy3;
  logic [10:0] rom_addr3;

  exp_t        sb_q[$];
  exp_t        e;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  iob_rom_arb #(.NUM_REQ(4), .ADDR_W(11), .DATA_W(32)) dut (
    .clk(clk), .arst_n(arst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .rom_r_en(rom_r_en), .rom_addr(rom_addr),
    .rom_r_data(rom_r_data), .busy(busy)
  );

  iob_rom_arb #(.NUM_REQ(3), .ADDR_W(11), .DATA_W(32)) dut3 (
    .clk(clk), .arst_n(arst_n), .req_valid(req_valid3), .req_addr(req_addr3),
    .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
    .rsp_ready(rsp_ready3), .rom_r_en(rom_r_en3), .rom_addr(rom_addr3),
    .rom_r_data(rom_r_data3), .busy(busy3)
  );

  function automatic logic [31:0] rom_fn(input logic [10:0] a);
    return {21'd0, a} * 32'h0101_0101;
  endfunction

  initial rom_r_data  = '0;
  initial rom_r_data3 = '0;
  always @(posedge clk) if (rom_r_en)  rom_r_data  <= rom_fn(rom_addr);
  always @(posedge clk) if (rom_r_en3) rom_r_data3 <= rom_fn(rom_addr3);

  // Pulse reset and return aligned one time unit after a rising edge.
  task automatic do_reset();
    arst_n = 1'b0;
    req_valid = '0; req_valid3 = '0;
    rsp_ready = '1; rsp_ready3 = '1;
    #2 arst_n = 1'b1;
    @(posedge clk); #1;
    sb_q.delete();
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    req_valid = '1; req_addr = '1; rsp_ready = '1;
    req_valid3 = '1; req_addr3 = '0; rsp_ready3 = '1;
    #1;
    n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    n_vec++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
    n_vec++; if (rom_r_en !== 1'b0) begin n_err++; $display("FAIL reset_rom_r_en got %b want 0", rom_r_en); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (rom_addr !== 11'd0) begin n_err++; $display("FAIL reset_rom_addr got %h want 000", rom_addr); end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req_addr = '0; req_addr[2*11 +: 11] = 11'd5; req_valid = 4'b0100;
    #4;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_grant got %b want 0100", req_ready); end
    n_vec++; if (rom_r_en !== 1'b1 || rom_addr !== 11'd5) begin n_err++; $display("FAIL single_rom got en=%b addr=%h want en=1 addr=005", rom_r_en, rom_addr); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_pre got %b want 0", busy); end
    sb_q.push_back('{lane: 2, data: rom_fn(11'd5)});
    @(posedge clk); #1; req_valid = '0;
    #4;
    e = sb_q.pop_front();
    n_vec++; if (rsp_valid !== (4'b0001 << e.lane)) begin n_err++; $display("FAIL single_rsp_valid got %b want lane %0d", rsp_valid, e.lane); end
    n_vec++; if (rsp_data !== e.data) begin n_err++; $display("FAIL single_rsp_data got %h want %h", rsp_data, e.data); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b want 1", busy); end
    @(posedge clk); #5;
    n_vec++; if (busy !== 1'b0 || rsp_valid !== 4'b0) begin n_err++; $display("FAIL single_done got busy=%b rsp_valid=%b want 0/0000", busy, rsp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < 4; i++) req_addr[i*11 +: 11] = 11'(i);
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #4;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_vec++; if (rsp_valid !== (4'b0001 << e.lane) || rsp_data !== e.data) begin n_err++; $display("FAIL rr_rsp[%0d] got valid=%b data=%h want lane %0d data=%h", c, rsp_valid, rsp_data, e.lane, e.data); end
      end
      n_vec++; if (req_ready !== (4'b0001 << (c % 4)) || rom_r_en !== 1'b1 || rom_addr !== 11'(c % 4)) begin n_err++; $display("FAIL rr_grant[%0d] got ready=%b en=%b addr=%h want lane %0d", c, req_ready, rom_r_en, rom_addr, c % 4); end
      sb_q.push_back('{lane: c % 4, data: rom_fn(11'(c % 4))});
      @(posedge clk); #1;
    end
    req_valid = '0;
    #4;
    e = sb_q.pop_front();
    n_vec++; if (rsp_valid !== (4'b0001 << e.lane) || rsp_data !== e.data) begin n_err++; $display("FAIL rr_rsp_last got valid=%b data=%h want lane %0d data=%h", rsp_valid, rsp_data, e.lane, e.data); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_addr = '0; req_addr[1*11 +: 11] = 11'd7; req_addr[3*11 +: 11] = 11'd9;
    req_valid = 4'b0010; rsp_ready = 4'b1101;
    #4;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_grant1 got %b want 0010", req_ready); end
    sb_q.push_back('{lane: 1, data: rom_fn(11'd7)});
    @(posedge clk); #1; req_valid = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      #4;
      n_vec++; if (rsp_valid !== 4'b0010 || rsp_data !== 32'h0707_0707) begin n_err++; $display("FAIL bp_hold[%0d] got valid=%b data=%h want 0010 07070707", c, rsp_valid, rsp_data); end
      n_vec++; if (req_ready !== 4'b0 || rom_r_en !== 1'b0) begin n_err++; $display("FAIL bp_stall[%0d] got ready=%b en=%b want 0000/0", c, req_ready, rom_r_en); end
      @(posedge clk); #1;
    end
    rsp_ready = 4'b1111;
    #4;
    e = sb_q.pop_front();
    n_vec++; if (rsp_valid !== (4'b0001 << e.lane) || rsp_data !== e.data) begin n_err++; $display("FAIL bp_rsp1 got valid=%b data=%h want lane %0d data=%h", rsp_valid, rsp_data, e.lane, e.data); end
    n_vec++; if (req_ready !== 4'b1000 || rom_r_en !== 1'b1 || rom_addr !== 11'd9) begin n_err++; $display("FAIL bp_grant3 got ready=%b en=%b addr=%h want 1000/1/009", req_ready, rom_r_en, rom_addr); end
    sb_q.push_back('{lane: 3, data: rom_fn(11'd9)});
    @(posedge clk); #1; req_valid = '0;
    #4;
    e = sb_q.pop_front();
    n_vec++; if (rsp_valid !== (4'b0001 << e.lane) || rsp_data !== e.data) begin n_err++; $display("FAIL bp_rsp3 got valid=%b data=%h want lane %0d data=%h", rsp_valid, rsp_data, e.lane, e.data); end
    @(posedge clk); #1;
  endtask

  task automatic test_skip_idle();
    int lane;
    do_reset();
    req_addr = '0; req_addr[0 +: 11] = 11'h10; req_addr[3*11 +: 11] = 11'h13;
    req_valid = 4'b1001;
    for (int c = 0; c < 6; c++) begin
      lane = (c % 2 == 0) ? 0 : 3;
      #4;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_vec++; if (rsp_valid !== (4'b0001 << e.lane) || rsp_data !== e.data) begin n_err++; $display("FAIL skip_rsp[%0d] got valid=%b data=%h want lane %0d data=%h", c, rsp_valid, rsp_data, e.lane, e.data); end
      end
      n_vec++; if (req_ready !== (4'b0001 << lane)) begin n_err++; $display("FAIL skip_grant[%0d] got %b want lane %0d", c, req_ready, lane); end
      sb_q.push_back('{lane: lane, data: rom_fn(11'h10 + 11'(lane / 3 * 3))});
      @(posedge clk); #1;
    end
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_addr = '0; req_addr[2*11 +: 11] = 11'd4;
    req_valid = 4'b0100; rsp_ready = 4'b0000;
    #4;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL mid_grant got %b want 0100", req_ready); end
    @(posedge clk); #1; req_valid = '0;
    #1;
    n_vec++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL mid_pending got %b want 0100", rsp_valid); end
    req_addr[0 +: 11] = 11'h20; req_addr[3*11 +: 11] = 11'h23;
    req_valid = 4'b1001;
    arst_n = 1'b0;
    #1;
    n_vec++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_async_rsp got valid=%b busy=%b want 0000/0", rsp_valid, busy); end
    n_vec++; if (req_ready !== 4'b0 || rom_r_en !== 1'b0 || rom_addr !== 11'd0) begin n_err++; $display("FAIL mid_async_req got ready=%b en=%b addr=%h want 0000/0/000", req_ready, rom_r_en, rom_addr); end
    #1 arst_n = 1'b1; rsp_ready = 4'b1111;
    #1;
    sb_q.delete();
    n_vec++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL mid_no_stale got %b want 0000", rsp_valid); end
    n_vec++; if (req_ready !== 4'b0001 || rom_addr !== 11'h20) begin n_err++; $display("FAIL mid_first_grant got ready=%b addr=%h want 0001/020", req_ready, rom_addr); end
    sb_q.push_back('{lane: 0, data: rom_fn(11'h20)});
    @(posedge clk); #1;
    #4;
    e = sb_q.pop_front();
    n_vec++; if (rsp_valid !== (4'b0001 << e.lane) || rsp_data !== e.data) begin n_err++; $display("FAIL mid_rsp0 got valid=%b data=%h want lane %0d data=%h", rsp_valid, rsp_data, e.lane, e.data); end
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL mid_second_grant got %b want 1000", req_ready); end
    @(posedge clk); #1; req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap3();
    do_reset();
    for (int i = 0; i < 3; i++) req_addr3[i*11 +: 11] = 11'h30 + 11'(i);
    req_valid3 = 3'b111;
    for (int c = 0; c < 4; c++) begin
      #4;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        n_vec++; if (rsp_valid3 !== (3'b001 << e.lane) || rsp_data3 !== e.data) begin n_err++; $display("FAIL wrap3_rsp[%0d] got valid=%b data=%h want lane %0d data=%h", c, rsp_valid3, rsp_data3, e.lane, e.data); end
      end
      n_vec++; if (req_ready3 !== (3'b001 << (c % 3)) || rom_addr3 !== 11'h30 + 11'(c % 3)) begin n_err++; $display("FAIL wrap3_grant[%0d] got ready=%b addr=%h want lane %0d", c, req_ready3, rom_addr3, c % 3); end
      sb_q.push_back('{lane: c % 3, data: rom_fn(11'h30 + 11'(c % 3))});
      @(posedge clk); #1;
    end
    req_valid3 = '0;
    #4;
    e = sb_q.pop_front();
    n_vec++; if (rsp_valid3 !== (3'b001 << e.lane) || rsp_data3 !== e.data) begin n_err++; $display("FAIL wrap3_rsp_last got valid=%b data=%h want lane %0d data=%h", rsp_valid3, rsp_data3, e.lane, e.data); end
    @(posedge clk); #1;
  endtask

  initial begin
    arst_n = 1'b0;
    req_valid = '0; req_addr = '0; rsp_ready = '1;
    req_valid3 = '0; req_addr3 = '0; rsp_ready3 = '1;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_skip_idle();
    test_reset_mid();
    test_wrap3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iob_rom_arb.md
Name: iob_rom_arb

Overview:
- Round-robin arbiter that shares one synchronous-read ROM port (1-cycle read latency, r_data held while r_en low) between NUM_REQ requesters.
- Requests and responses use valid/ready handshakes on each lane.
- One read in flight per arbiter, throughput of one read per cycle when responses are accepted immediately.
- Sits between CPU/DMA-side ROM readers and one port of a ROM instance.

Parameters:
NUM_REQ, 4, number of requester lanes (2..16)
ADDR_W, 11, ROM address width
DATA_W, 32, ROM data width
ID_W, localparam = clog2(NUM_REQ) (min 1), width of the internal lane index

Ports:
clk  in  1  clock, all state on rising edge
arst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-lane read request valid
req_addr  in  NUM_REQ*ADDR_W  per-lane address, lane i at bits [i*ADDR_W +: ADDR_W]
req_ready  out  NUM_REQ  per-lane request accepted (one-hot or zero)
rsp_valid  out  NUM_REQ  per-lane response valid (one-hot or zero)
rsp_data  out  DATA_W  response data, shared by all lanes, meaningful on the lane with rsp_valid set
rsp_ready  in  NUM_REQ  per-lane response accept
rom_r_en  out  1  ROM read enable
rom_addr  out  ADDR_W  ROM read address
rom_r_data  in  DATA_W  ROM read data, valid the cycle after rom_r_en, held while rom_r_en low
busy  out  1  high while a response is outstanding (rsp_valid non-zero)

Behaviour:
- State:
  - rsp_pend_q (1 bit).
  - rsp_id_q (ID_W).
  - last_q (ID_W): lane granted most recently.
- Reset (arst_n low, asynchronous):
  - rsp_pend_q=0, rsp_id_q=0, last_q=NUM_REQ-1.
  - All outputs are low: req_ready=0, rsp_valid=0, rom_r_en=0, busy=0.
  - rom_addr=0 and rsp_data is passed through from rom_r_data.
- rsp_fire = rsp_pend_q & rsp_ready[rsp_id_q].
- Issue window: can_issue = !rsp_pend_q | rsp_fire.
- Arbitration (combinational):
  - Among lanes with req_valid set, pick the first lane searching upward from last_q+1, wrapping modulo NUM_REQ.
  - Lane last_q has the lowest priority.
- Issue:
  - Issue happens when can_issue is high and any req_valid is set. On issue:
    - req_ready[pick]=1 in the same cycle.
    - rom_r_en=1 and rom_addr = req_addr of pick.
    - At the clock edge: rsp_pend_q<=1, rsp_id_q<=pick, last_q<=pick.
  - When there is no issue:
    - req_ready=0 and rom_r_en=0.
    - rom_addr=0.
    - rsp_pend_q<=0 if rsp_fire, otherwise it holds.
    - last_q holds.
- Response:
  - rsp_valid[rsp_id_q] = rsp_pend_q; all other rsp_valid bits are 0.
  - rsp_data = rom_r_data, passed through with no register.
  - Read latency: rsp_valid rises the cycle after req_ready.
- Backpressure:
  - While rsp_pend_q is set and rsp_ready of that lane is low, no issue occurs.
  - rom_r_en stays low, so rom_r_data (and therefore rsp_data) stays stable until the response is accepted.
- Same-cycle events:
  - A response can be accepted and a new request issued in the same cycle, on the same lane or a different lane. This gives back-to-back one-per-cycle throughput.
- Handshake dependency:
  - req_ready depends combinationally on req_valid and rsp_ready.
  - Requesters must not make req_valid depend on req_ready.
  - Once req_valid is raised, req_addr must be held stable until req_ready is seen.
- Unused inputs:
  - rsp_ready bits of lanes with no pending response are ignored.
  - req_addr of lanes that are not picked is ignored.
- Reset mid-operation: a pending response is dropped, and no rsp_valid is seen after reset release until a new issue.
- Wrap-around:
  - last_q+1 wraps from NUM_REQ-1 to 0.
  - A non-power-of-two NUM_REQ wraps at NUM_REQ, not at 2^ID_W.

Test Plan:
- Single request: ROM preloaded with rom[k]=k*0x01010101; lane 2 requests addr 5 with rsp_ready held high. Required:
  - req_ready[2]=1 in the same cycle.
  - rsp_valid=4'b0100 one cycle later with rsp_data=0x05050505.
  - busy=1 for exactly one cycle.
- Round-robin fairness: all 4 lanes hold req_valid with addr = lane index, rsp_ready all high, 8 cycles after reset. Required:
  - Grant order 0,1,2,3,0,1,2,3.
  - One rom_r_en per cycle.
  - Responses return data 0x00000000, 0x01010101, 0x02020202, 0x03030303 in that order.
- Backpressure: lane 1 issues addr 7, then holds rsp_ready[1]=0 for 5 cycles while lane 3 requests. Required:
  - rsp_valid[1] is held and rsp_data=0x07070707 is stable.
  - req_ready[3]=0 and rom_r_en=0 during the stall.
  - In the cycle rsp_ready[1] rises, lane 3 is issued.
- Skip idle lanes: only lanes 0 and 3 request continuously. Required: grants alternate 0,3,0,3; lanes 1 and 2 never see req_ready.
- Reset mid-operation: arst_n pulled low asynchronously while rsp_valid[2]=1. Required:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release with lanes 0 and 3 requesting, lane 0 is granted first.
- NUM_REQ=3 build: lanes 0, 1 and 2 all request. Required: grant order 0,1,2,0, confirming wrap at 3 with no grant to nonexistent lane 3.
